// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide sequencer.
//   - md_op_e    : 3-bit MD operation encodings carried on md_op
//   - md_state_e : sequencer FSM states (IDLE, RUN)
//   - MD_MULT_CYCLES / MD_DIV_CYCLES : default busy latencies
//   - md_is_start : true for the multi-cycle ops (mult/multu/div/divu)
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5,
      MD_MFHI  = 3'd6,
      MD_MFLO  = 3'd7
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   localparam int unsigned MD_MULT_CYCLES = 5;
   localparam int unsigned MD_DIV_CYCLES  = 10;

   function automatic logic md_is_start(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// md_sequencer_if: E-stage <-> MD sequencer signal bundle.
//   master (core side) drives : md_valid, md_op, rs_data, rt_data, d_is_md
//                               (+ md_cancel when MD_SEQUENCER_CANCEL_EN is defined)
//   slave (sequencer) drives  : busy, stall, md_rdata, hi, lo
interface md_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic             md_valid;
   logic [2:0]       md_op;
   logic [WIDTH-1:0] rs_data;
   logic [WIDTH-1:0] rt_data;
   logic             d_is_md;
   logic             busy;
   logic             stall;
   logic [WIDTH-1:0] md_rdata;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
`ifdef MD_SEQUENCER_CANCEL_EN
   logic             md_cancel;

   modport master (
      output md_valid, md_op, rs_data, rt_data, d_is_md, md_cancel,
      input  busy, stall, md_rdata, hi, lo
   );
   modport slave (
      input  md_valid, md_op, rs_data, rt_data, d_is_md, md_cancel,
      output busy, stall, md_rdata, hi, lo
   );
`else
   modport master (
      output md_valid, md_op, rs_data, rt_data, d_is_md,
      input  busy, stall, md_rdata, hi, lo
   );
   modport slave (
      input  md_valid, md_op, rs_data, rt_data, d_is_md,
      output busy, stall, md_rdata, hi, lo
   );
`endif
endinterface

// File: rtl/md_calc.sv
// md_calc: purely combinational multiply/divide datapath.
//   op          : MD operation (only mult/multu/div/divu produce a result)
//   a, b        : rs / rt operands
//   hi_nxt      : product upper half, or remainder
//   lo_nxt      : product lower half, or quotient
//   div_by_zero : divide op with b == 0 (result must not be committed)
module md_calc
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt,
   output logic             div_by_zero
);

   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic [WIDTH-1:0]   div_u_b;
   logic [WIDTH-1:0]   div_s_b;
   logic [WIDTH-1:0]   quot_s, rem_s, quot_u, rem_u;
   logic               s_ovf;

   assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   // Zero divisor is replaced by 1 so the divider never sees x/0; the result is discarded.
   assign div_u_b = (b == '0) ? WIDTH'(1) : b;
   // MIN / -1 overflows; dividing by 1 instead yields the wrapped quotient MIN with rem 0.
   assign s_ovf   = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
   assign div_s_b = s_ovf ? WIDTH'(1) : div_u_b;

   assign quot_s = $signed(a) / $signed(div_s_b);
   assign rem_s  = $signed(a) % $signed(div_s_b);
   assign quot_u = a / div_u_b;
   assign rem_u  = a % div_u_b;

   assign div_by_zero = (b == '0) && ((op == MD_DIV) || (op == MD_DIVU));

   always_comb begin
      hi_nxt = '0;
      lo_nxt = '0;
      case (op)
         MD_MULT:  {hi_nxt, lo_nxt} = prod_s;
         MD_MULTU: {hi_nxt, lo_nxt} = prod_u;
         MD_DIV:   begin hi_nxt = rem_s; lo_nxt = quot_s; end
         MD_DIVU:  begin hi_nxt = rem_u; lo_nxt = quot_u; end
         default:  ;
      endcase
   end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: E-stage multiply/divide sequencer owning HI/LO.
//   clk, reset : core clock, asynchronous active-high reset
//   bus        : md_sequencer_if slave (md_valid/md_op/rs_data/rt_data/d_is_md in;
//                busy/stall/md_rdata/hi/lo out)
// Optional: MD_SEQUENCER_CANCEL_EN adds bus.md_cancel, which aborts a running op and
// suppresses a same-cycle start or mthi/mtlo.
module md_sequencer
   import md_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
   input logic            clk,
   input logic            reset,
   md_sequencer_if.slave  bus
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   md_state_e        state_q, state_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] hi_nxt_q, hi_nxt_d, lo_nxt_q, lo_nxt_d;
   logic [WIDTH-1:0] hi_calc, lo_calc;
   logic             div_by_zero;
   logic             start;
   logic             cancel;
   logic             is_mul;

`ifdef MD_SEQUENCER_CANCEL_EN
   assign cancel = bus.md_cancel;
`else
   assign cancel = 1'b0;
`endif

   md_calc #(
      .WIDTH (WIDTH)
   ) u_calc (
      .op          (bus.md_op),
      .a           (bus.rs_data),
      .b           (bus.rt_data),
      .hi_nxt      (hi_calc),
      .lo_nxt      (lo_calc),
      .div_by_zero (div_by_zero)
   );

   assign start  = bus.md_valid && md_is_start(bus.md_op);
   assign is_mul = (bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      hi_nxt_d = hi_nxt_q;
      lo_nxt_d = lo_nxt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.md_valid && !cancel) begin
               if (start) begin
                  // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
                  hi_nxt_d = div_by_zero ? hi_q : hi_calc;
                  lo_nxt_d = div_by_zero ? lo_q : lo_calc;
                  count_d  = is_mul ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                  state_d  = RUN;
               end else if (bus.md_op == MD_MTHI) begin
                  hi_d = bus.rs_data;
               end else if (bus.md_op == MD_MTLO) begin
                  lo_d = bus.rs_data;
               end
            end
         end
         RUN: begin
            // md_valid here is a protocol violation and is ignored.
            if (cancel) begin
               state_d = IDLE;
               count_d = '0;
            end else if (count_q == CntW'(1)) begin
               hi_d    = hi_nxt_q;
               lo_d    = lo_nxt_q;
               state_d = IDLE;
               count_d = '0;
            end else begin
               count_d = count_q - CntW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         hi_nxt_q <= '0;
         lo_nxt_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         hi_nxt_q <= hi_nxt_d;
         lo_nxt_q <= lo_nxt_d;
      end
   end

   assign bus.busy     = (state_q == RUN);
   assign bus.stall    = bus.d_is_md && (bus.busy || start);
   assign bus.md_rdata = (bus.md_op == MD_MFHI) ? hi_q : lo_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

`ifndef SYNTHESIS
   a_no_op_while_busy : assert property (@(posedge clk) disable iff (reset)
      !(bus.md_valid && (state_q == RUN)))
      else $error("md_sequencer: md_valid asserted while busy");
`endif

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;
   import md_pkg::*;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   logic [31:0] hi_m, lo_m;

   md_sequencer_if #(.WIDTH(32)) mif ();

   md_sequencer #(
      .WIDTH       (32),
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference behaviour of HI/LO after an op, from the architectural definition.
   task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, p, q, r;
      longint unsigned pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         MD_MULT:  begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
         MD_MULTU: begin pu = 64'(a) * 64'(b); hi_m = pu[63:32]; lo_m = pu[31:0]; end
         MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
         MD_DIVU:  if (b != 0) begin lo_m = a / b; hi_m = a % b; end
         MD_MTHI:  hi_m = a;
         MD_MTLO:  lo_m = a;
         default:  ;
      endcase
   endtask

   // Issue one MD op in a single E-stage cycle and follow it to completion.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd);
      int  exp_n;
      int  n_busy;
      logic st;
      logic done;
      st    = md_is_start(op);
      exp_n = (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
      @(negedge clk);
      mif.md_valid = 1'b1;
      mif.md_op    = op;
      mif.rs_data  = a;
      mif.rt_data  = b;
      mif.d_is_md  = dmd;
      #1;
      check_eq("start_stall", 64'(mif.stall), 64'(dmd & st));
      check_eq("start_busy", 64'(mif.busy), 64'd0);
      if (op == MD_MFHI) check_eq("mfhi_rdata", 64'(mif.md_rdata), 64'(hi_m));
      if (op == MD_MFLO) check_eq("mflo_rdata", 64'(mif.md_rdata), 64'(lo_m));
      ref_model(op, a, b);
      if (st) begin
         n_busy = 0;
         done   = 1'b0;
         for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            mif.md_valid = 1'b0;
            mif.md_op    = 3'($urandom_range(0, 7));
            #1;
            if (mif.busy) begin
               n_busy++;
               check_eq("busy_stall", 64'(mif.stall), 64'(dmd));
            end else begin
               done = 1'b1;
            end
         end
         check_eq("busy_cycles", 64'(n_busy), 64'(exp_n));
         check_eq("end_stall", 64'(mif.stall), 64'd0);
      end else begin
         @(negedge clk);
         mif.md_valid = 1'b0;
         #1;
         check_eq("nobusy", 64'(mif.busy), 64'd0);
      end
      check_eq("hi", 64'(mif.hi), 64'(hi_m));
      check_eq("lo", 64'(mif.lo), 64'(lo_m));
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      n_tests = 0;
      n_fail  = 0;
      hi_m    = '0;
      lo_m    = '0;
      reset   = 1'b1;
      mif.md_valid = 1'b0;
      mif.md_op    = MD_MFLO;
      mif.rs_data  = '0;
      mif.rt_data  = '0;
      mif.d_is_md  = 1'b1;
`ifdef MD_SEQUENCER_CANCEL_EN
      mif.md_cancel = 1'b0;
`endif
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_busy", 64'(mif.busy), 64'd0);
      check_eq("rst_hi", 64'(mif.hi), 64'd0);
      check_eq("rst_lo", 64'(mif.lo), 64'd0);
      check_eq("rst_stall", 64'(mif.stall), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed cases with hand-computed results.
      do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
      check_eq("mult_hi_k", 64'(mif.hi), 64'hFFFF_FFFF);
      check_eq("mult_lo_k", 64'(mif.lo), 64'hFFFF_FFFA);
      do_op(MD_MFLO, 32'd0, 32'd0, 1'b1);
      do_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
      check_eq("multu_hi_k", 64'(mif.hi), 64'h0000_0002);
      check_eq("multu_lo_k", 64'(mif.lo), 64'hFFFF_FFFA);
      do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
      check_eq("div_hi_k", 64'(mif.hi), 64'hFFFF_FFFF);
      check_eq("div_lo_k", 64'(mif.lo), 64'hFFFF_FFFD);
      do_op(MD_DIVU, 32'd7, 32'd0, 1'b0);
      check_eq("dbz_hi_k", 64'(mif.hi), 64'hFFFF_FFFF);
      check_eq("dbz_lo_k", 64'(mif.lo), 64'hFFFF_FFFD);
      do_op(MD_MTHI, 32'h1234_5678, 32'd0, 1'b1);
      do_op(MD_MFHI, 32'd0, 32'd0, 1'b1);
      check_eq("mthi_k", 64'(mif.hi), 64'h1234_5678);
      do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

      // Reset in the middle of a divide: immediate clear, no late write afterwards.
      @(negedge clk);
      mif.md_valid = 1'b1;
      mif.md_op    = MD_DIV;
      mif.rs_data  = 32'd100;
      mif.rt_data  = 32'd3;
      @(negedge clk);
      mif.md_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_eq("arst_busy", 64'(mif.busy), 64'd0);
      check_eq("arst_hi", 64'(mif.hi), 64'd0);
      check_eq("arst_lo", 64'(mif.lo), 64'd0);
      hi_m = '0;
      lo_m = '0;
      @(negedge clk);
      reset = 1'b0;
      repeat (14) @(negedge clk);
      #1;
      check_eq("post_rst_busy", 64'(mif.busy), 64'd0);
      check_eq("post_rst_hi", 64'(mif.hi), 64'd0);
      check_eq("post_rst_lo", 64'(mif.lo), 64'd0);

`ifdef MD_SEQUENCER_CANCEL_EN
      do_op(MD_MTHI, 32'hA, 32'd0, 1'b0);
      do_op(MD_MTLO, 32'hB, 32'd0, 1'b0);
      @(negedge clk);
      mif.md_valid = 1'b1;
      mif.md_op    = MD_MULT;
      mif.rs_data  = 32'd4;
      mif.rt_data  = 32'd4;
      @(negedge clk);
      mif.md_valid = 1'b0;
      @(negedge clk);
      mif.md_cancel = 1'b1;
      #1;
      check_eq("cancel_busy_before", 64'(mif.busy), 64'd1);
      @(negedge clk);
      mif.md_cancel = 1'b0;
      #1;
      check_eq("cancel_busy", 64'(mif.busy), 64'd0);
      check_eq("cancel_hi", 64'(mif.hi), 64'hA);
      check_eq("cancel_lo", 64'(mif.lo), 64'hB);
      @(negedge clk);
      mif.md_valid  = 1'b1;
      mif.md_op     = MD_MTHI;
      mif.rs_data   = 32'h55;
      mif.md_cancel = 1'b1;
      @(negedge clk);
      mif.md_valid  = 1'b0;
      mif.md_cancel = 1'b0;
      #1;
      check_eq("cancel_mthi", 64'(mif.hi), 64'hA);
`endif

      // Randomized ops interleaved with non-MD cycles.
      for (int k = 0; k < 60; k++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(1, 9));
         do_op(rop, ra, rb, 1'($urandom_range(0, 1)));
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            @(negedge clk);
            mif.md_valid = 1'b0;
            mif.md_op    = 3'($urandom_range(0, 7));
            mif.rs_data  = $urandom;
            mif.d_is_md  = 1'($urandom_range(0, 1));
            #1;
            check_eq("idle_stall", 64'(mif.stall), 64'd0);
            check_eq("idle_hi", 64'(mif.hi), 64'(hi_m));
            check_eq("idle_lo", 64'(mif.lo), 64'(lo_m));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
